stdout_fifo: RTL and testbench
==============================

# stdout_fifo

Buffered console-output stage between the core's memory-mapped bus and the `tty_tx` serializer. Byte writes to the DATA register are queued in a DEPTH-entry FIFO and drained to `tty_tx` through a valid/ready handshake. The core stalls only when the FIFO is full; it no longer waits for each character to leave the wire. A STATUS register exposes fill level and allows a flush.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `BASE`, 'h3000: bus address of DATA; STATUS is at `BASE+4`.
- `clk`  in  1  Single clock; all state changes on its rising edge.
- `rst`  in  1  Reset: synchronous, active-high.
- `addr`  in  32  Core bus address.
- `valid`  in  1  Core bus request; held until `ready`.
- `write`  in  1  1 = write, 0 = read.
- `wdata`  in  32  Write data; DATA uses `[7:0]`, STATUS uses `[0]`.
- `rdata`  out  32  Read data; valid while `ready`=1.
- `ready`  out  1  Transfer complete; one-cycle pulse.
- `sel`  out  1  Combinational: `valid` && (`addr`==`BASE` || `addr`==`BASE+4`). Used by the top-level mux.
- `tx_valid`  out  1  Byte available to `tty_tx`.
- `tx_data`  out  8  Head-of-FIFO byte.
- `tx_ready`  in  1  `tty_tx` accepts the byte this cycle.

## Operation
- Storage:
  - `DEPTH`×8 memory.
  - `rd_ptr` and `wr_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, log2(DEPTH)+1 bits, range 0..DEPTH.
  - full = (`count`==DEPTH); empty = (`count`==0).
- Bus FSM states: IDLE, ACK.
  - IDLE → ACK when `sel` and the access is admissible; the access executes on that same edge.
  - ACK lasts exactly one cycle with `ready`=1, then returns to IDLE.
  - No request is sampled while in ACK, so a held `valid` cannot double-push.
- Admissibility and effect:
  - DATA write: admissible only when not full. Pushes `wdata[7:0]` at `wr_ptr`; `wr_ptr`++.
  - DATA write while full: FSM stays in IDLE with `ready`=0 and the core stalls. It is admitted on the first cycle the FIFO is not full.
  - DATA read: always admissible; `rdata`=0.
  - STATUS read: always admissible. `rdata` = {16'b0, count (zero-extended to 8 bits) at `[15:8]`, 6'b0, empty at `[1]`, full at `[0]`}, sampled on the accept edge.
  - STATUS write with `wdata[0]`=1: flush. `rd_ptr`, `wr_ptr` and `count` are cleared. A pop on the same edge is discarded.
  - STATUS write with `wdata[0]`=0: no effect; still acknowledged.
- Drain side:
  - `tx_valid` = !empty; `tx_data` = mem[`rd_ptr`].
  - Pop when `tx_valid` && `tx_ready`; `rd_ptr`++.
  - `tx_data` is stable while `tx_valid`=1 and no pop occurs.
- Count arithmetic:
  - push only: +1; pop only: −1; push and pop together: unchanged.
  - Full is evaluated on pre-edge state, so a write to a full FIFO is not admitted even if a pop happens on the same edge. It is admitted the next cycle.
- `sel`=0 leaves the FSM idle; `ready` stays 0 and the top-level mux ignores `rdata`.

## Timing
- Reset values: FSM=IDLE, `ready`=0, `rdata`=0, `tx_valid`=0, `tx_data` don't-care, `count`=0, `rd_ptr`=`wr_ptr`=0.
- Reset mid-operation:
  - Queued bytes are lost.
  - A pending ACK is cancelled, with `ready`=0 in the cycle after `rst`.
  - A byte already taken by `tty_tx` is unaffected.
- Bus latency, non-full case: `valid` sampled at edge N; `ready`=1 during cycle N+1. Minimum 2 cycles per access.
- Push to drain: byte pushed at edge N into an empty FIFO gives `tx_valid`=1 from cycle N+1.
- Peak throughput: one push per 2 cycles and one pop per cycle.
- Pointer wrap: after `wr_ptr`=DEPTH−1 the next value is 0, with no bubble.

## Test plan
- Reset, then write 'H','i' to 'h3000 with `tx_ready` held 0. Required: each write gets `ready` 1 cycle after `valid`; STATUS read returns 'h0200; `tx_valid`=1 with `tx_data`='H'.
- DEPTH=16, `tx_ready`=0, 17 writes. Required: writes 1–16 acked; STATUS = 'h1001; write 17 stalls. Pulse `tx_ready` for one cycle: write 17 is acked on the following cycle and count returns to 16.
- Push 40 bytes 0..39 while `tx_ready` toggles pseudo-randomly. Required: `tty_tx` receives 0..39 in order with no loss or duplication (covers pointer wrap and simultaneous push/pop); final STATUS = 'h0002.
- Queue 5 bytes, then write 1 to 'h3004 while `tx_ready`=1. Required: next cycle `tx_valid`=0 and STATUS = 'h0002; next byte pushed appears as `tx_data`.
- Queue 3 bytes, assert `rst` for 1 cycle while ACK is pending. Required: `ready`=0, `tx_valid`=0, STATUS read after reset = 'h0002.
- Read 'h3000 → `rdata`=0 with `ready` pulse. Access to 'h1000 → `sel`=0 and `ready` stays 0.

Source files
------------

// File: rtl/stdout_fifo_if.sv
// Core bus port plus tty_tx drain handshake of the console output FIFO.
interface stdout_fifo_if;
    logic [31:0] addr;
    logic        valid;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sel;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport slave (
        input  addr, valid, write, wdata, tx_ready,
        output rdata, ready, sel, tx_valid, tx_data
    );

    modport master (
        output addr, valid, write, wdata, tx_ready,
        input  rdata, ready, sel, tx_valid, tx_data
    );
endinterface

// File: rtl/stdout_fifo.sv
// Buffered console output: bus byte writes queue into a FIFO drained to tty_tx.
module stdout_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter logic [31:0] BASE  = 32'h3000
) (
    input logic          clk,
    input logic          rst,
    stdout_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {IDLE, ACK} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            full, empty;
    logic            is_data, is_stat;
    logic            accept, push, pop, flush;
    logic [31:0]     status_word;
    logic            unused_wdata;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign is_data = (bus.addr == BASE);
    assign is_stat = (bus.addr == BASE + 32'd4);
    assign bus.sel = bus.valid && (is_data || is_stat);

    assign status_word  = {16'b0, 8'(count), 6'b0, empty, full};
    assign unused_wdata = ^bus.wdata[31:8];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Requests are only looked at in IDLE, so a held valid cannot be taken twice.
    always_comb begin
        state_nxt = IDLE;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.sel && !(is_data && bus.write && full)) begin
                    accept    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ready = (state == ACK);

    assign push  = accept && is_data && bus.write;
    assign flush = accept && is_stat && bus.write && bus.wdata[0];
    assign pop   = !empty && bus.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rdata <= '0;
        end else if (accept && is_stat && !bus.write) begin
            bus.rdata <= status_word;
        end else begin
            bus.rdata <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wdata[7:0];
    end

    // Flush overrides any same-edge pop; push and flush never coincide (different addresses).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = mem[rd_ptr];
endmodule

// File: tb/tb_stdout_fifo.sv
// Randomized self-checking bench for stdout_fifo against a queue reference model.
module tb_stdout_fifo;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h3000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_popped = 0;
    logic [7:0] model_q[$];

    stdout_fifo_if bus ();

    stdout_fifo #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte queue fed by acknowledged DATA writes, emptied by flush/reset.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            model_q.delete();
        end else begin
            if (bus.ready === 1'b1 && bus.write === 1'b1) begin
                if (bus.addr == BASE)
                    model_q.push_back(bus.wdata[7:0]);
                else if (bus.addr == BASE + 32'd4 && bus.wdata[0])
                    model_q.delete();
            end
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                check("pop_avail", 32'(model_q.size() != 0), 32'd1);
                if (model_q.size() != 0) begin
                    check("tx_data", {24'b0, bus.tx_data}, {24'b0, model_q.pop_front()});
                    n_popped++;
                end
            end
        end
    end

    task automatic bus_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd, output int lat);
        bus.addr  = a;
        bus.write = w;
        bus.wdata = d;
        bus.valid = 1'b1;
        @(negedge clk);
        check("sel", {31'b0, bus.sel}, 32'd1);
        lat = 1;
        while (bus.ready !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("ack_seen", {31'b0, bus.ready}, 32'd1);
        rd = bus.rdata;
        tick();
        bus.valid = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    int          pop_base;
    int          k;
    bit          rnd_done;

    initial begin
        rst          = 1'b1;
        bus.valid    = 1'b0;
        bus.write    = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.tx_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, bus.ready}, 32'd0);
        check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        tick();

        // 'H','i' with no drain
        bus_xfer(BASE, 1'b1, 32'h48, rd, lat);
        check("lat_H", 32'(lat), 32'd2);
        bus_xfer(BASE, 1'b1, 32'h69, rd, lat);
        check("lat_i", 32'(lat), 32'd2);
        bus_xfer(BASE + 32'd4, 1'b0, '0, rd, lat);
        check("status_2", rd, 32'h0000_0200);
        @(negedge clk);
        check("tv_H", {31'b0, bus.tx_valid}, 32'd1);
        check("td_H", {24'b0, bus.tx_data}, 32'h48);
        tick();
        bus_xfer(BASE + 32'd4, 1'b1, 32'd1, rd, lat);
        check("lat_flush", 32'(lat), 32'd2);

        // fill to full, then one stalled write
        for (int i = 0; i < 16; i++) begin
            bus_xfer(BASE, 1'b1, $urandom_range(0, 255), rd, lat);
            check("lat_fill", 32'(lat), 32'd2);
        end
        bus_xfer(BASE + 32'd4, 1'b0, '0, rd, lat);
        check("status_full", rd, 32'h0000_1001);
        fork
            bus_xfer(BASE, 1'b1, 32'hC3, rd, lat);
            begin
                repeat (3) @(posedge clk);
                #1 bus.tx_ready = 1'b1;
                @(posedge clk);
                #1 bus.tx_ready = 1'b0;
            end
        join
        check("lat_stall", 32'(lat), 32'd6);
        bus_xfer(BASE + 32'd4, 1'b0, '0, rd, lat);
        check("status_refull", rd, 32'h0000_1001);

        // streaming with random drain
        bus_xfer(BASE + 32'd4, 1'b1, 32'd1, rd, lat);
        pop_base = n_popped;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) bus_xfer(BASE, 1'b1, 32'(i), rd, lat);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.tx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.tx_ready = 1'b1;
        k = 0;
        while (model_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        check("drain_done", 32'(k < 100), 32'd1);
        @(negedge clk);
        check("drain_tv", {31'b0, bus.tx_valid}, 32'd0);
        check("drain_count", 32'(n_popped - pop_base), 32'd40);
        tick();
        bus.tx_ready = 1'b0;
        bus_xfer(BASE + 32'd4, 1'b0, '0, rd, lat);
        check("status_empty", rd, 32'h0000_0002);

        // flush while draining
        for (int i = 0; i < 5; i++) bus_xfer(BASE, 1'b1, $urandom_range(0, 255), rd, lat);
        bus.tx_ready = 1'b1;
        bus_xfer(BASE + 32'd4, 1'b1, 32'd1, rd, lat);
        @(negedge clk);
        check("flush_tv", {31'b0, bus.tx_valid}, 32'd0);
        tick();
        bus.tx_ready = 1'b0;
        bus_xfer(BASE + 32'd4, 1'b0, '0, rd, lat);
        check("status_flush", rd, 32'h0000_0002);
        bus_xfer(BASE, 1'b1, 32'hA5, rd, lat);
        @(negedge clk);
        check("post_flush_tv", {31'b0, bus.tx_valid}, 32'd1);
        check("post_flush_td", {24'b0, bus.tx_data}, 32'hA5);
        tick();

        // STATUS write of 0 is acknowledged but leaves the queue alone
        bus_xfer(BASE + 32'd4, 1'b1, 32'd0, rd, lat);
        bus_xfer(BASE + 32'd4, 1'b0, '0, rd, lat);
        check("status_nop", rd, {16'b0, 8'(model_q.size()), 6'b0, 1'b0, 1'b0});

        // reset while an ACK is pending
        for (int i = 0; i < 3; i++) bus_xfer(BASE, 1'b1, $urandom_range(0, 255), rd, lat);
        bus.addr  = BASE;
        bus.write = 1'b1;
        bus.wdata = 32'h77;
        bus.valid = 1'b1;
        tick();
        rst       = 1'b1;
        bus.valid = 1'b0;
        @(negedge clk);
        check("ack_pending", {31'b0, bus.ready}, 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_ready", {31'b0, bus.ready}, 32'd0);
        check("rst2_tv", {31'b0, bus.tx_valid}, 32'd0);
        tick();
        bus_xfer(BASE + 32'd4, 1'b0, '0, rd, lat);
        check("status_rst", rd, 32'h0000_0002);

        // DATA read and foreign address
        bus_xfer(BASE, 1'b1, 32'h5A, rd, lat);
        bus_xfer(BASE, 1'b0, '0, rd, lat);
        check("data_rd", rd, 32'd0);
        check("lat_rd", 32'(lat), 32'd2);
        bus.addr  = 32'h1000;
        bus.write = 1'b0;
        bus.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sel_other", {31'b0, bus.sel}, 32'd0);
            check("ready_other", {31'b0, bus.ready}, 32'd0);
            tick();
        end
        bus.valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
